img_ram_arbiter: RTL and testbench

//   Owns the single-port image RAM (rw=1 read, rw=0 write, registered read data, 1-cycle latency).

---
 rtl/img_ram_arbiter.sv | 119 +++++++++++
 tb/tb_img_ram_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/img_ram_arbiter.sv
// Image RAM arbiter: shares one single-port RAM between a priority VGA reader
// and a UART byte stream that loads a frame into consecutive addresses.
module img_ram_arbiter #(
    parameter int AddressWidth = 14,
    parameter int DataWidth    = 8,
    parameter int ImagePixels  = 2**AddressWidth
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_frame_start,
    input  logic                    i_wr_valid,
    output logic                    o_wr_ready,
    input  logic [DataWidth-1:0]    i_wr_data,
    input  logic                    i_rd_req,
    input  logic [AddressWidth-1:0] i_rd_addr,
    output logic [DataWidth-1:0]    o_rd_data,
    output logic                    o_rd_valid,
    output logic                    o_loading,
    output logic                    o_frame_done,
    output logic [AddressWidth-1:0] o_wr_count,
    output logic                    o_ram_rw,
    output logic [AddressWidth-1:0] o_ram_addr,
    output logic [DataWidth-1:0]    o_ram_wdata,
    input  logic [DataWidth-1:0]    i_ram_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DONE
    } state_t;

    localparam logic [AddressWidth-1:0] LastAddr = AddressWidth'(ImagePixels - 1);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    r_pending;
    logic                    w_pending_nxt;
    logic [AddressWidth-1:0] r_wr_ptr;
    logic [AddressWidth-1:0] w_wr_ptr_nxt;
    logic                    r_frame_done;
    logic                    w_frame_done_nxt;
    logic [DataWidth-1:0]    r_hold;
    logic                    r_vld_p1;

    logic                    w_wr_ready;
    logic                    w_accept;
    logic                    w_wr_issue;

    // Reset and frame_start both mask the RAM write so a held byte can be dropped cleanly.
    assign w_wr_ready = (r_state == ST_LOAD) && !r_pending && !i_frame_start && !i_rst;
    assign w_accept   = i_wr_valid && w_wr_ready;
    assign w_wr_issue = r_pending && !i_rd_req && !i_frame_start && !i_rst;

    always_comb begin
        w_state_nxt      = r_state;
        w_pending_nxt    = r_pending;
        w_wr_ptr_nxt     = r_wr_ptr;
        w_frame_done_nxt = r_frame_done;
        if (i_frame_start) begin
            w_state_nxt      = ST_LOAD;
            w_pending_nxt    = 1'b0;
            w_wr_ptr_nxt     = '0;
            w_frame_done_nxt = 1'b0;
        end else if (w_wr_issue) begin
            w_pending_nxt = 1'b0;
            if (r_wr_ptr == LastAddr) begin
                w_wr_ptr_nxt     = '0;
                w_state_nxt      = ST_DONE;
                w_frame_done_nxt = 1'b1;
            end else begin
                w_wr_ptr_nxt = r_wr_ptr + 1'b1;
            end
        end else if (w_accept) begin
            w_pending_nxt = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_pending    <= 1'b0;
            r_wr_ptr     <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pending    <= w_pending_nxt;
            r_wr_ptr     <= w_wr_ptr_nxt;
            r_frame_done <= w_frame_done_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            r_hold <= i_wr_data;
        end
    end

    // Read stage p1: qualifier lines up with the RAM's registered read data.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_vld_p1 <= 1'b0;
        end else begin
            r_vld_p1 <= i_rd_req;
        end
    end

    assign o_ram_rw     = !w_wr_issue;
    assign o_ram_addr   = w_wr_issue ? r_wr_ptr : i_rd_addr;
    assign o_ram_wdata  = r_hold;

    assign o_wr_ready   = w_wr_ready;
    assign o_rd_data    = i_ram_rdata;
    assign o_rd_valid   = r_vld_p1;
    assign o_loading    = (r_state == ST_LOAD);
    assign o_frame_done = r_frame_done;
    assign o_wr_count   = r_wr_ptr;

endmodule

// File: tb/tb_img_ram_arbiter.sv
// Bench for img_ram_arbiter: directed steps with random data/gaps, a RAM model,
// and an expected-write scoreboard plus expected memory image.
module tb_img_ram_arbiter;

    localparam int AW  = 4;
    localparam int DW  = 8;
    localparam int PIX = 16;

    logic          clk;
    logic          i_rst;
    logic          i_frame_start;
    logic          i_wr_valid;
    logic          o_wr_ready;
    logic [DW-1:0] i_wr_data;
    logic          i_rd_req;
    logic [AW-1:0] i_rd_addr;
    logic [DW-1:0] o_rd_data;
    logic          o_rd_valid;
    logic          o_loading;
    logic          o_frame_done;
    logic [AW-1:0] o_wr_count;
    logic          o_ram_rw;
    logic [AW-1:0] o_ram_addr;
    logic [DW-1:0] o_ram_wdata;
    logic [DW-1:0] ram_rdata;

    img_ram_arbiter #(
        .AddressWidth(AW),
        .DataWidth   (DW),
        .ImagePixels (PIX)
    ) dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_frame_start(i_frame_start),
        .i_wr_valid   (i_wr_valid),
        .o_wr_ready   (o_wr_ready),
        .i_wr_data    (i_wr_data),
        .i_rd_req     (i_rd_req),
        .i_rd_addr    (i_rd_addr),
        .o_rd_data    (o_rd_data),
        .o_rd_valid   (o_rd_valid),
        .o_loading    (o_loading),
        .o_frame_done (o_frame_done),
        .o_wr_count   (o_wr_count),
        .o_ram_rw     (o_ram_rw),
        .o_ram_addr   (o_ram_addr),
        .o_ram_wdata  (o_ram_wdata),
        .i_ram_rdata  (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port RAM with registered read, as seen by the arbiter.
    logic [DW-1:0] ram_mem [PIX];
    always @(posedge clk) begin
        if (o_ram_rw === 1'b0) ram_mem[o_ram_addr] <= o_ram_wdata;
        ram_rdata <= ram_mem[o_ram_addr];
    end

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t           exp_wq[$];
    logic [DW-1:0] exp_mem [PIX];
    int            exp_ptr;
    bit            exp_done;
    int            n_cmp;
    int            n_err;
    bit            mon_en;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Every RAM write must match the next write the model predicted.
    always @(negedge clk) begin
        wr_t w;
        if (mon_en && o_ram_rw !== 1'b1) begin
            if (exp_wq.size() == 0) begin
                chk("unexpected_write", 32'(exp_wq.size()), 32'd1);
            end else begin
                w = exp_wq.pop_front();
                chk("wr_addr", 32'(o_ram_addr), 32'(w.addr));
                chk("wr_data", 32'(o_ram_wdata), 32'(w.data));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_frame_start();
        i_frame_start = 1'b1;
        step();
        i_frame_start = 1'b0;
        exp_ptr  = 0;
        exp_done = 1'b0;
        #1;
        chk("fs_loading", 32'(o_loading), 32'd1);
        chk("fs_wr_count", 32'(o_wr_count), 32'd0);
    endtask

    // Presents one byte and returns just after the edge that accepted it.
    task automatic send_byte(input logic [DW-1:0] d);
        int n;
        n = 0;
        i_wr_valid = 1'b1;
        i_wr_data  = d;
        #1;
        while (o_wr_ready !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk("wr_accept", 32'(o_wr_ready), 32'd1);
        step();
        i_wr_valid = 1'b0;
    endtask

    task automatic load_byte(input logic [DW-1:0] d);
        send_byte(d);
        exp_wq.push_back('{addr: AW'(exp_ptr), data: d});
        step();
        exp_mem[exp_ptr] = d;
        if (exp_ptr == PIX - 1) begin
            exp_ptr  = 0;
            exp_done = 1'b1;
        end else begin
            exp_ptr++;
        end
        chk("wr_count", 32'(o_wr_count), 32'(exp_ptr));
        chk("frame_done", 32'(o_frame_done), 32'(exp_done));
        chk("loading", 32'(o_loading), 32'(!exp_done));
    endtask

    // Back-to-back reads over [lo,hi] in random order, checked against the model image.
    task automatic read_range(input int lo, input int hi);
        logic [AW-1:0] q[$];
        logic [AW-1:0] tmp;
        for (int a = lo; a <= hi; a++) q.push_back(AW'(a));
        for (int i = q.size() - 1; i > 0; i--) begin
            int j;
            j    = int'($urandom_range(i, 0));
            tmp  = q[i];
            q[i] = q[j];
            q[j] = tmp;
        end
        for (int i = 0; i <= q.size(); i++) begin
            if (i < q.size()) begin
                i_rd_req  = 1'b1;
                i_rd_addr = q[i];
            end else begin
                i_rd_req = 1'b0;
            end
            #1;
            if (i > 0) begin
                chk("rd_valid", 32'(o_rd_valid), 32'd1);
                chk("rd_data", 32'(o_rd_data), 32'(exp_mem[q[i-1]]));
            end
            step();
        end
        chk("rd_valid_end", 32'(o_rd_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [DW-1:0] b;
        n_cmp = 0; n_err = 0; mon_en = 1'b0;
        exp_ptr = 0; exp_done = 1'b0;
        for (int i = 0; i < PIX; i++) begin
            ram_mem[i] = '0;
            exp_mem[i] = '0;
        end
        i_rst = 1'b1; i_frame_start = 1'b0; i_wr_valid = 1'b0; i_wr_data = '0;
        i_rd_req = 1'b0; i_rd_addr = '0;

        // Reset
        step();
        step();
        chk("rst_wr_ready", 32'(o_wr_ready), 32'd0);
        chk("rst_ram_rw", 32'(o_ram_rw), 32'd1);
        chk("rst_rd_valid", 32'(o_rd_valid), 32'd0);
        chk("rst_frame_done", 32'(o_frame_done), 32'd0);
        chk("rst_loading", 32'(o_loading), 32'd0);
        chk("rst_wr_count", 32'(o_wr_count), 32'd0);
        i_rst = 1'b0;
        mon_en = 1'b1;
        step();
        chk("idle_wr_ready", 32'(o_wr_ready), 32'd0);

        // Full load of 0x00..0x0F with random gaps
        pulse_frame_start();
        for (int i = 0; i < PIX; i++) begin
            int gap;
            gap = int'($urandom_range(2, 0));
            for (int g = 0; g < gap; g++) step();
            load_byte(DW'(i));
        end
        i_wr_valid = 1'b1;
        i_wr_data  = 8'hEE;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("done_wr_ready", 32'(o_wr_ready), 32'd0);
            step();
        end
        i_wr_valid = 1'b0;
        chk("done_hold", 32'(o_frame_done), 32'd1);
        read_range(0, PIX - 1);

        // Read priority over a pending write
        pulse_frame_start();
        send_byte(8'hAA);
        for (int k = 1; k <= 5; k++) begin
            i_rd_req  = 1'b1;
            i_rd_addr = 4'd3;
            #1;
            chk("prio_rw", 32'(o_ram_rw), 32'd1);
            chk("prio_addr", 32'(o_ram_addr), 32'd3);
            chk("prio_rd_valid", 32'(o_rd_valid), 32'(k >= 2));
            if (k >= 2) chk("prio_rd_data", 32'(o_rd_data), 32'(exp_mem[3]));
            step();
        end
        exp_wq.push_back('{addr: AW'(exp_ptr), data: 8'hAA});
        i_rd_req = 1'b0;
        #1;
        chk("prio_wr_rw", 32'(o_ram_rw), 32'd0);
        chk("prio_wr_addr", 32'(o_ram_addr), 32'd0);
        chk("prio_wr_data", 32'(o_ram_wdata), 32'hAA);
        chk("prio_rd_valid6", 32'(o_rd_valid), 32'd1);
        step();
        exp_mem[0] = 8'hAA;
        exp_ptr    = 1;
        chk("prio_wr_count", 32'(o_wr_count), 32'd1);
        chk("prio_rd_valid7", 32'(o_rd_valid), 32'd0);

        // frame_start coincident with wr_valid
        i_frame_start = 1'b1;
        i_wr_valid    = 1'b1;
        i_wr_data     = 8'h55;
        #1;
        chk("coin_wr_ready", 32'(o_wr_ready), 32'd0);
        step();
        i_frame_start = 1'b0;
        i_wr_valid    = 1'b0;
        exp_ptr       = 0;
        #1;
        chk("coin_wr_ready_next", 32'(o_wr_ready), 32'd1);
        chk("coin_no_pending", 32'(o_ram_rw), 32'd1);
        chk("coin_wr_count", 32'(o_wr_count), 32'd0);
        step();
        chk("coin_wr_count2", 32'(o_wr_count), 32'd0);

        // Restart with one byte pending
        for (int i = 0; i < 6; i++) load_byte(DW'($urandom));
        send_byte(DW'($urandom));
        i_frame_start = 1'b1;
        #1;
        chk("restart_rw", 32'(o_ram_rw), 32'd1);
        step();
        i_frame_start = 1'b0;
        exp_ptr  = 0;
        exp_done = 1'b0;
        #1;
        chk("restart_wr_count", 32'(o_wr_count), 32'd0);
        chk("restart_wr_ready", 32'(o_wr_ready), 32'd1);
        load_byte(8'h77);

        // Reset mid-load with one byte pending
        pulse_frame_start();
        for (int i = 0; i < 5; i++) load_byte(DW'($urandom));
        b = DW'($urandom);
        send_byte(b);
        i_rst = 1'b1;
        #1;
        chk("midrst_rw", 32'(o_ram_rw), 32'd1);
        chk("midrst_wr_ready", 32'(o_wr_ready), 32'd0);
        step();
        i_rst = 1'b0;
        exp_ptr  = 0;
        exp_done = 1'b0;
        #1;
        chk("midrst_loading", 32'(o_loading), 32'd0);
        chk("midrst_wr_count", 32'(o_wr_count), 32'd0);
        chk("midrst_frame_done", 32'(o_frame_done), 32'd0);
        chk("midrst_wr_ready2", 32'(o_wr_ready), 32'd0);
        step();
        read_range(0, 4);

        step();
        chk("writes_outstanding", 32'(exp_wq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
